// File: rtl/vga_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM encoding for the rectangle filler.
package vga_pkg;

  localparam logic [2:0] RegX0     = 3'd0;
  localparam logic [2:0] RegY0     = 3'd1;
  localparam logic [2:0] RegWidth  = 3'd2;
  localparam logic [2:0] RegHeight = 3'd3;
  localparam logic [2:0] RegColor  = 3'd4;
  localparam logic [2:0] RegCtrl   = 3'd5;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlIrqEnBit = 1;
  localparam int unsigned CtrlClrBit   = 2;

  localparam int unsigned StatBusyBit  = 0;
  localparam int unsigned StatDoneBit  = 1;
  localparam int unsigned StatIrqEnBit = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StFill   = 2'd2,
    StFinish = 2'd3
  } state_e;

endpackage

// File: rtl/vga_rect_walker.sv
// Pixel walker: steps x/y across the clipped rectangle and forms the linear word address.
module vga_rect_walker #(
  parameter int unsigned H_RES = 160
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [9:0]  i_x0,
  input  logic [9:0]  i_xe,
  input  logic [8:0]  i_y0,
  input  logic [8:0]  i_ye,
  output logic [15:0] o_address,
  output logic        o_last
);

  localparam logic [15:0] HResW = 16'(H_RES);

  logic [9:0]  r_x, r_x0, r_xe;
  logic [8:0]  r_y, r_ye;
  logic [15:0] r_rowbase;
  logic        w_row_end;

  assign w_row_end = (r_x == r_xe - 10'd1);
  assign o_last    = w_row_end && (r_y == r_ye - 9'd1);
  assign o_address = r_rowbase + 16'(r_x);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x       <= '0;
      r_x0      <= '0;
      r_xe      <= '0;
      r_y       <= '0;
      r_ye      <= '0;
      r_rowbase <= '0;
    end else if (i_load) begin
      r_x       <= i_x0;
      r_x0      <= i_x0;
      r_xe      <= i_xe;
      r_y       <= i_y0;
      r_ye      <= i_ye;
      r_rowbase <= 16'(i_y0) * HResW;
    end else if (i_step) begin
      if (w_row_end) begin
        r_x       <= r_x0;
        r_y       <= r_y + 9'd1;
        r_rowbase <= r_rowbase + HResW;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Avalon-MM rectangle filler: CPU-programmed registers drive a walker that writes one pixel/cycle.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int unsigned H_RES = 160,
  parameter int unsigned V_RES = 120
) (
  input  logic        dataClock,
  input  logic        resetn,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        irq
);

  localparam logic [9:0] HResW = 10'(H_RES);
  localparam logic [8:0] VResW = 9'(V_RES);

  state_e      r_state, w_state_next;
  logic [8:0]  r_x0, r_width;
  logic [7:0]  r_y0, r_height;
  logic [23:0] r_color;
  logic        r_irq_en, r_done;
  logic [31:0] r_readdata;

  logic        w_wr, w_rd, w_busy, w_ctrl_wr, w_start, w_step, w_last, w_empty, w_load;
  logic [9:0]  w_xe_sum, w_xe;
  logic [8:0]  w_ye_sum, w_ye;
  logic [15:0] w_addr;
  logic [31:0] w_status;
  logic        w_unused_wdata;

  assign w_unused_wdata = ^writedata[31:24];

  assign w_wr      = chipselect & write;
  assign w_rd      = chipselect & read;
  assign w_busy    = (r_state != StIdle);
  assign w_ctrl_wr = w_wr && (address == RegCtrl);
  assign w_start   = w_ctrl_wr && writedata[CtrlStartBit] && !w_busy;
  assign w_step    = (r_state == StFill) && !m_waitrequest;

  // Extents widened one bit so X0+WIDTH / Y0+HEIGHT never wrap before clipping.
  assign w_xe_sum = {1'b0, r_x0} + {1'b0, r_width};
  assign w_ye_sum = {1'b0, r_y0} + {1'b0, r_height};
  assign w_xe     = (w_xe_sum > HResW) ? HResW : w_xe_sum;
  assign w_ye     = (w_ye_sum > VResW) ? VResW : w_ye_sum;
  assign w_empty  = ({1'b0, r_x0} >= w_xe) || ({1'b0, r_y0} >= w_ye);
  assign w_load   = (r_state == StSetup) && !w_empty;

  vga_rect_walker #(
    .H_RES (H_RES)
  ) u_walker (
    .i_clk     (dataClock),
    .i_rst_n   (resetn),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_x0      ({1'b0, r_x0}),
    .i_xe      (w_xe),
    .i_y0      ({1'b0, r_y0}),
    .i_ye      (w_ye),
    .o_address (w_addr),
    .o_last    (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_start) w_state_next = StSetup;
      StSetup:  w_state_next = w_empty ? StFinish : StFill;
      StFill:   if (w_step && w_last) w_state_next = StFinish;
      StFinish: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge dataClock or negedge resetn) begin
    if (!resetn) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge dataClock or negedge resetn) begin
    if (!resetn) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_color  <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_wr && !w_busy) begin
        case (address)
          RegX0:     r_x0     <= writedata[8:0];
          RegY0:     r_y0     <= writedata[7:0];
          RegWidth:  r_width  <= writedata[8:0];
          RegHeight: r_height <= writedata[7:0];
          RegColor:  r_color  <= writedata[23:0];
          default:   ;
        endcase
      end
      if (w_ctrl_wr) r_irq_en <= writedata[CtrlIrqEnBit];
      // Completion takes priority over a clear landing on the same edge.
      if (r_state == StFinish)                   r_done <= 1'b1;
      else if (w_ctrl_wr && writedata[CtrlClrBit]) r_done <= 1'b0;
    end
  end

  always_comb begin
    w_status               = '0;
    w_status[StatBusyBit]  = w_busy;
    w_status[StatDoneBit]  = r_done;
    w_status[StatIrqEnBit] = r_irq_en;
  end

  always_ff @(posedge dataClock or negedge resetn) begin
    if (!resetn)   r_readdata <= '0;
    else if (w_rd) r_readdata <= (address == RegCtrl) ? w_status : 32'd0;
  end

  assign readdata    = r_readdata;
  assign m_write     = (r_state == StFill);
  assign m_address   = w_addr;
  assign m_writedata = m_write ? {8'h00, r_color} : 32'd0;
  assign irq         = r_done & r_irq_en;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: fills, clipping, empty commands, stalls, irq and reset abort.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [15:0] m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] cap_a[$];
  logic [31:0] cap_d[$];

  always #5 clk = ~clk;

  vga_rect_fill #(
    .H_RES (160),
    .V_RES (120)
  ) dut (
    .dataClock     (clk),
    .resetn        (resetn),
    .chipselect    (chipselect),
    .write         (write),
    .read          (read),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .irq           (irq)
  );

  // Accepted pixel writes, sampled mid-cycle while the bus is stable.
  always @(negedge clk) begin
    if (resetn && m_write && !m_waitrequest) begin
      cap_a.push_back(m_address);
      cap_d.push_back(m_writedata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic setup_rect(input int x0, input int y0, input int w, input int h,
                            input logic [23:0] col);
    cpu_write(3'd0, 32'(x0));
    cpu_write(3'd1, 32'(y0));
    cpu_write(3'd2, 32'(w));
    cpu_write(3'd3, 32'(h));
    cpu_write(3'd4, {8'h00, col});
  endtask

  task automatic wait_done();
    logic [31:0] s;
    int k;
    s = 32'd1;
    k = 0;
    while (s[0] && k < 50) begin
      cpu_read(3'd5, s);
      k++;
    end
    chk("wait_done_busy", {31'd0, s[0]}, 32'd0);
  endtask

  task automatic chk_addrs(input string tag, input int base, input int n,
                           input int unsigned ea[8], input logic [31:0] data);
    chk({tag, "_count"}, 32'(cap_a.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < cap_a.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), {16'd0, cap_a[base + i]}, ea[i]);
        chk($sformatf("%s_data%0d", tag, i), cap_d[base + i], data);
      end
    end
  endtask

  initial begin
    logic [31:0] s;
    int base;
    int unsigned ea[8];

    // Reset values while resetn is held low
    #12;
    chk("rst_m_write", 32'(m_write), 32'd0);
    chk("rst_m_address", 32'(m_address), 32'd0);
    chk("rst_m_writedata", m_writedata, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cpu_read(3'd5, s);
    chk("rst_status", s, 32'd0);

    // 3x2 fill at (10,5)
    setup_rect(10, 5, 3, 2, 24'hFF0000);
    base = cap_a.size();
    cpu_write(3'd5, 32'd1);
    chk("t1_setup_no_write", 32'(m_write), 32'd0);
    tick(1);
    chk("t1_first_write", 32'(m_write), 32'd1);
    chk("t1_first_addr", 32'(m_address), 32'd810);
    wait_done();
    ea = '{810, 811, 812, 970, 971, 972, 0, 0};
    chk_addrs("t1", base, 6, ea, 32'h00FF0000);
    cpu_read(3'd5, s);
    chk("t1_status", s, 32'd2);

    // Clipped at the bottom-right corner; start+clear in one write
    setup_rect(158, 119, 10, 10, 24'h00ABCD);
    base = cap_a.size();
    cpu_write(3'd5, 32'd5);
    cpu_read(3'd5, s);
    chk("t2_busy_done_cleared", s, 32'd1);
    wait_done();
    ea = '{19198, 19199, 0, 0, 0, 0, 0, 0};
    chk_addrs("t2", base, 2, ea, 32'h0000ABCD);

    // Zero width: done visible three cycles after start, via irq
    setup_rect(10, 5, 0, 2, 24'h111111);
    base = cap_a.size();
    cpu_write(3'd5, 32'd7);
    chk("t3_irq_c1", 32'(irq), 32'd0);
    tick(1);
    chk("t3_irq_c2", 32'(irq), 32'd0);
    tick(1);
    chk("t3_irq_c3", 32'(irq), 32'd1);
    chk("t3_count", 32'(cap_a.size() - base), 32'd0);
    cpu_write(3'd5, 32'd4);
    chk("t3_irq_cleared", 32'(irq), 32'd0);

    // X0 beyond screen; a clear arriving on the FINISH edge loses to done
    setup_rect(200, 5, 3, 2, 24'h222222);
    base = cap_a.size();
    cpu_write(3'd5, 32'd1);
    tick(1);
    cpu_write(3'd5, 32'd4);
    cpu_read(3'd5, s);
    chk("t4_done_wins", s, 32'd2);
    chk("t4_count", 32'(cap_a.size() - base), 32'd0);

    // Stall on the second pixel for four cycles
    setup_rect(0, 0, 3, 1, 24'h123456);
    base = cap_a.size();
    cpu_write(3'd5, 32'd5);
    tick(2);
    m_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_hold_addr%0d", i), 32'(m_address), 32'd1);
      chk($sformatf("t5_hold_data%0d", i), m_writedata, 32'h00123456);
      chk($sformatf("t5_hold_wr%0d", i), 32'(m_write), 32'd1);
      tick(1);
    end
    m_waitrequest = 1'b0;
    chk("t5_hold_addr4", 32'(m_address), 32'd1);
    tick(1);
    chk("t5_next_addr", 32'(m_address), 32'd2);
    wait_done();
    ea = '{0, 1, 2, 0, 0, 0, 0, 0};
    chk_addrs("t5", base, 3, ea, 32'h00123456);

    // irq after a 2x2 fill; writes to X0 and start while busy are ignored
    setup_rect(0, 0, 2, 2, 24'h00FF00);
    base = cap_a.size();
    cpu_write(3'd5, 32'd7);
    cpu_write(3'd0, 32'd50);
    cpu_write(3'd5, 32'd3);
    wait_done();
    chk("t6_irq_high", 32'(irq), 32'd1);
    tick(3);
    ea = '{0, 1, 160, 161, 0, 0, 0, 0};
    chk_addrs("t6", base, 4, ea, 32'h0000FF00);
    cpu_write(3'd5, 32'd6);
    chk("t6_irq_low", 32'(irq), 32'd0);
    cpu_read(3'd5, s);
    chk("t6_status", s, 32'd4);
    base = cap_a.size();
    cpu_write(3'd5, 32'd1);
    wait_done();
    chk_addrs("t6_rerun", base, 4, ea, 32'h0000FF00);

    // Reset in the middle of a fill
    setup_rect(0, 0, 10, 10, 24'h0000FF);
    cpu_write(3'd5, 32'd7);
    tick(5);
    chk("t7_filling", 32'(m_write), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t7_rst_m_write", 32'(m_write), 32'd0);
    chk("t7_rst_m_address", 32'(m_address), 32'd0);
    chk("t7_rst_m_writedata", m_writedata, 32'd0);
    chk("t7_rst_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cpu_read(3'd5, s);
    chk("t7_status_after", s, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
